// File: rtl/option_index_sched.sv
// Merges the case and nocase index buffers into one engine stream, lowest byte offset first.
// Optional tie statistics counter: OPT_SCHED_STATS_EN.
module option_index_sched #(
    parameter logic [10:0] TYPE_BASE  = 11'd0,
    parameter logic [10:0] OFFSET_ADJ = 11'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] a_dout,
    input  logic        a_empty,
    output logic        a_rd_en,
    input  logic [21:0] b_dout,
    input  logic        b_empty,
    output logic        b_rd_en,
    input  logic        eop,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [10:0] out_index,
    output logic [10:0] out_offset,
    output logic        out_from_b,
    output logic        flush_done
`ifdef OPT_SCHED_STATS_EN
    ,
    output logic [15:0] stat_ties
`endif
);

    typedef enum logic {
        S_RUN,
        S_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rr;
    logic        r_vld_p1;
    logic [10:0] r_index_p1;
    logic [10:0] r_offset_p1;
    logic        r_from_b_p1;
    logic        r_flush_done;
    logic        w_flush_nxt;

    logic [10:0] w_a_off;
    logic [10:0] w_b_off;
    logic        w_slot_free;
    logic        w_a_wins;
    logic        w_pop_a;
    logic        w_pop_b;
    logic        w_pop;
    logic [21:0] w_sel;

    function automatic logic [10:0] f_sub_base(input logic [10:0] idx);
        return idx - TYPE_BASE;
    endfunction

    function automatic logic [10:0] f_add_adj(input logic [10:0] off);
        return off + OFFSET_ADJ;
    endfunction

    assign w_a_off     = a_dout[10:0];
    assign w_b_off     = b_dout[10:0];
    assign w_slot_free = !r_vld_p1 || out_ready;

    // Equal offsets fall back to the round-robin bit, which flips on every pop.
    always_comb begin
        w_a_wins = 1'b0;
        if (a_empty)
            w_a_wins = 1'b0;
        else if (b_empty)
            w_a_wins = 1'b1;
        else if (w_a_off != w_b_off)
            w_a_wins = (w_a_off < w_b_off);
        else
            w_a_wins = r_rr;
    end

    assign w_pop_a = w_slot_free && w_a_wins;
    assign w_pop_b = w_slot_free && !b_empty && !w_a_wins;
    assign w_pop   = w_pop_a || w_pop_b;
    assign w_sel   = w_pop_b ? b_dout : a_dout;
    assign a_rd_en = w_pop_a;
    assign b_rd_en = w_pop_b;

    always_comb begin
        w_state_nxt = r_state;
        w_flush_nxt = 1'b0;
        case (r_state)
            S_RUN: begin
                if (eop)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (a_empty && b_empty && w_slot_free) begin
                    w_flush_nxt = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Stage p1: output register toward the engine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_rr         <= 1'b0;
            r_flush_done <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_index_p1   <= 11'd0;
            r_offset_p1  <= 11'd0;
            r_from_b_p1  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_done <= w_flush_nxt;
            if (w_pop) begin
                r_vld_p1    <= 1'b1;
                r_index_p1  <= f_sub_base(w_sel[21:11]);
                r_offset_p1 <= f_add_adj(w_sel[10:0]);
                r_from_b_p1 <= w_pop_b;
                r_rr        <= ~r_rr;
            end else if (w_slot_free) begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

`ifdef OPT_SCHED_STATS_EN
    logic [15:0] r_stat_ties;
    logic        w_tie;

    assign w_tie = !a_empty && !b_empty && (w_a_off == w_b_off);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stat_ties <= 16'd0;
        else if (w_pop && w_tie && (r_stat_ties != 16'hFFFF))
            r_stat_ties <= r_stat_ties + 16'd1;
    end

    assign stat_ties = r_stat_ties;
`endif

    assign out_valid  = r_vld_p1;
    assign out_index  = r_index_p1;
    assign out_offset = r_offset_p1;
    assign out_from_b = r_from_b_p1;
    assign flush_done = r_flush_done;

endmodule

// File: tb/tb_option_index_sched.sv
// Directed bench for option_index_sched: default instance plus a TYPE_BASE=100 / OFFSET_ADJ=1 instance.
module tb_option_index_sched;

    logic        clk;
    logic        rst;
    logic [21:0] a_dout;
    logic        a_empty;
    logic [21:0] b_dout;
    logic        b_empty;
    logic        eop;
    logic        out_ready;

    logic        a_rd_en, b_rd_en, out_valid, out_from_b, flush_done;
    logic [10:0] out_index, out_offset;
    logic        a_rd_en1, b_rd_en1, out_valid1, out_from_b1, flush_done1;
    logic [10:0] out_index1, out_offset1;
`ifdef OPT_SCHED_STATS_EN
    logic [15:0] stat_ties, stat_ties1;
`endif

    logic [21:0] qa[$];
    logic [21:0] qb[$];
    logic        s_ra, s_rb;
    int          n_tests;
    int          n_fail;

    option_index_sched dut0 (
        .clk(clk), .rst(rst),
        .a_dout(a_dout), .a_empty(a_empty), .a_rd_en(a_rd_en),
        .b_dout(b_dout), .b_empty(b_empty), .b_rd_en(b_rd_en),
        .eop(eop), .out_ready(out_ready),
        .out_valid(out_valid), .out_index(out_index), .out_offset(out_offset),
        .out_from_b(out_from_b), .flush_done(flush_done)
`ifdef OPT_SCHED_STATS_EN
        , .stat_ties(stat_ties)
`endif
    );

    option_index_sched #(.TYPE_BASE(11'd100), .OFFSET_ADJ(11'd1)) dut1 (
        .clk(clk), .rst(rst),
        .a_dout(a_dout), .a_empty(a_empty), .a_rd_en(a_rd_en1),
        .b_dout(b_dout), .b_empty(b_empty), .b_rd_en(b_rd_en1),
        .eop(eop), .out_ready(out_ready),
        .out_valid(out_valid1), .out_index(out_index1), .out_offset(out_offset1),
        .out_from_b(out_from_b1), .flush_done(flush_done1)
`ifdef OPT_SCHED_STATS_EN
        , .stat_ties(stat_ties1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    typedef struct {
        logic        a_e;
        logic [10:0] a_idx;
        logic [10:0] a_off;
        logic        b_e;
        logic [10:0] b_idx;
        logic [10:0] b_off;
        logic        exp_ra;
        logic        exp_rb;
        logic        exp_vld;
        logic [10:0] exp_idx;
        logic [10:0] exp_off;
        logic        exp_fb;
        logic [10:0] exp_idx1;
        logic [10:0] exp_off1;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Present buffer heads, let combinational paths settle, latch the pop requests.
    task automatic settle();
        a_empty = (qa.size() == 0);
        a_dout  = a_empty ? 22'd0 : qa[0];
        b_empty = (qb.size() == 0);
        b_dout  = b_empty ? 22'd0 : qb[0];
        #1;
        s_ra = a_rd_en;
        s_rb = b_rd_en;
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            if (s_ra && qa.size() > 0) qa.delete(0);
            if (s_rb && qb.size() > 0) qb.delete(0);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        eop = 1'b0;
        out_ready = 1'b1;
        qa.delete();
        qb.delete();
        settle();
        advance();
        advance();
        rst = 1'b0;
    endtask

    initial begin
        int exp_a[5];
        int exp_b[5];
        int exp_i[5];
        int exp_fl[6];

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        eop = 1'b0;
        out_ready = 1'b1;
        a_dout = 22'd0; b_dout = 22'd0; a_empty = 1'b1; b_empty = 1'b1;

        vecs[0] = '{1'b0, 11'd5,    11'd20,   1'b1, 11'd0,  11'd0,    1'b1, 1'b0, 1'b1, 11'd5,    11'd20,   1'b0, 11'd1953, 11'd21};
        vecs[1] = '{1'b1, 11'd0,    11'd0,    1'b0, 11'd9,  11'd12,   1'b0, 1'b1, 1'b1, 11'd9,    11'd12,   1'b1, 11'd1957, 11'd13};
        vecs[2] = '{1'b0, 11'd7,    11'd30,   1'b0, 11'd9,  11'd12,   1'b0, 1'b1, 1'b1, 11'd9,    11'd12,   1'b1, 11'd1957, 11'd13};
        vecs[3] = '{1'b0, 11'd7,    11'd10,   1'b0, 11'd9,  11'd12,   1'b1, 1'b0, 1'b1, 11'd7,    11'd10,   1'b0, 11'd1955, 11'd11};
        vecs[4] = '{1'b0, 11'd1,    11'd4,    1'b0, 11'd11, 11'd4,    1'b0, 1'b1, 1'b1, 11'd11,   11'd4,    1'b1, 11'd1959, 11'd5};
        vecs[5] = '{1'b0, 11'd150,  11'd2047, 1'b1, 11'd0,  11'd0,    1'b1, 1'b0, 1'b1, 11'd150,  11'd2047, 1'b0, 11'd50,   11'd0};
        vecs[6] = '{1'b0, 11'd2047, 11'd0,    1'b0, 11'd0,  11'd2047, 1'b1, 1'b0, 1'b1, 11'd2047, 11'd0,    1'b0, 11'd1947, 11'd1};
        vecs[7] = '{1'b1, 11'd0,    11'd0,    1'b1, 11'd0,  11'd0,    1'b0, 1'b0, 1'b0, 11'd0,    11'd0,    1'b0, 11'd0,    11'd0};

        @(negedge clk);
        do_reset();

        // reset state
        settle();
        chk("rst_valid", out_valid, 0);
        chk("rst_index", out_index, 0);
        chk("rst_offset", out_offset, 0);
        chk("rst_from_b", out_from_b, 0);
        chk("rst_flush", flush_done, 0);
        chk("rst_rd", {a_rd_en, b_rd_en}, 0);
`ifdef OPT_SCHED_STATS_EN
        chk("rst_ties", stat_ties, 0);
`endif

        // single-cycle selection table
        for (int i = 0; i < 8; i++) begin
            do_reset();
            if (!vecs[i].a_e) qa.push_back({vecs[i].a_idx, vecs[i].a_off});
            if (!vecs[i].b_e) qb.push_back({vecs[i].b_idx, vecs[i].b_off});
            settle();
            chk($sformatf("v%0d_a_rd_en", i), a_rd_en, vecs[i].exp_ra);
            chk($sformatf("v%0d_b_rd_en", i), b_rd_en, vecs[i].exp_rb);
            chk($sformatf("v%0d_rd_en1", i), {a_rd_en1, b_rd_en1}, {vecs[i].exp_ra, vecs[i].exp_rb});
            advance();
            qa.delete();
            qb.delete();
            settle();
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].exp_vld);
            chk($sformatf("v%0d_index", i), out_index, vecs[i].exp_idx);
            chk($sformatf("v%0d_offset", i), out_offset, vecs[i].exp_off);
            chk($sformatf("v%0d_from_b", i), out_from_b, vecs[i].exp_fb);
            chk($sformatf("v%0d_valid1", i), out_valid1, vecs[i].exp_vld);
            chk($sformatf("v%0d_from_b1", i), out_from_b1, vecs[i].exp_fb);
            chk($sformatf("v%0d_index1", i), out_index1, vecs[i].exp_idx1);
            chk($sformatf("v%0d_offset1", i), out_offset1, vecs[i].exp_off1);
        end

        // B (offset 12) before A (offset 30), back to back
        do_reset();
        qa.push_back({11'd7, 11'd30});
        qb.push_back({11'd9, 11'd12});
        settle();
        chk("ba_pop0", {a_rd_en, b_rd_en}, 2'b01);
        advance();
        settle();
        chk("ba_pop1", {a_rd_en, b_rd_en}, 2'b10);
        chk("ba_out0", {out_valid, out_from_b, out_offset}, {1'b1, 1'b1, 11'd12});
        advance();
        settle();
        chk("ba_out1", {out_valid, out_from_b, out_index, out_offset}, {1'b1, 1'b0, 11'd7, 11'd30});
        advance();
        settle();
        chk("ba_idle", out_valid, 0);

        // equal-offset pairs fed one pair at a time
        do_reset();
        for (int k = 0; k < 3; k++) begin
            qa.push_back({11'(k + 1), 11'd4});
            qb.push_back({11'(k + 11), 11'd4});
            settle();
            chk($sformatf("tie%0d_pop_b", k), {a_rd_en, b_rd_en}, 2'b01);
            if (k > 0)
                chk($sformatf("tie%0d_prev_a", k), {out_valid, out_from_b, out_index}, {1'b1, 1'b0, 11'(k)});
            advance();
            settle();
            chk($sformatf("tie%0d_pop_a", k), {a_rd_en, b_rd_en}, 2'b10);
            chk($sformatf("tie%0d_out_b", k), {out_valid, out_from_b, out_index}, {1'b1, 1'b1, 11'(k + 11)});
            advance();
        end
        settle();
        chk("tie_last_a", {out_valid, out_from_b, out_index}, {1'b1, 1'b0, 11'd3});
`ifdef OPT_SCHED_STATS_EN
        chk("tie_stat", stat_ties, 3);
        chk("tie_stat1", stat_ties1, 3);
`endif

        // backpressure for 4 cycles, then one pop per cycle
        do_reset();
        qa.push_back({11'd1, 11'd10});
        qa.push_back({11'd2, 11'd20});
        qa.push_back({11'd3, 11'd30});
        qb.push_back({11'd4, 11'd15});
        qb.push_back({11'd5, 11'd25});
        settle();
        chk("bp_first_pop", {a_rd_en, b_rd_en}, 2'b10);
        advance();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk($sformatf("bp_hold%0d_rd", c), {a_rd_en, b_rd_en}, 2'b00);
            chk($sformatf("bp_hold%0d_out", c), {out_valid, out_index, out_offset}, {1'b1, 11'd1, 11'd10});
            advance();
        end
        out_ready = 1'b1;
        exp_a = '{0, 1, 0, 1, 0};
        exp_b = '{1, 0, 1, 0, 0};
        exp_i = '{1, 4, 2, 5, 3};
        for (int c = 0; c < 5; c++) begin
            settle();
            chk($sformatf("bp_run%0d_rd", c), {a_rd_en, b_rd_en}, {exp_a[c][0], exp_b[c][0]});
            chk($sformatf("bp_run%0d_out", c), {out_valid, out_index}, {1'b1, 11'(exp_i[c])});
            advance();
        end
        settle();
        chk("bp_idle", out_valid, 0);

        // drain with two entries queued
        do_reset();
        qa.push_back({11'd1, 11'd5});
        qb.push_back({11'd2, 11'd6});
        eop = 1'b1;
        exp_fl = '{0, 0, 0, 1, 0, 0};
        for (int c = 0; c < 6; c++) begin
            settle();
            chk($sformatf("drain%0d_flush", c), flush_done, exp_fl[c]);
            chk($sformatf("drain%0d_flush1", c), flush_done1, exp_fl[c]);
            advance();
            eop = 1'b0;
        end

        // eop with nothing queued and no output pending
        eop = 1'b1;
        settle();
        chk("edrain0_flush", flush_done, 0);
        advance();
        eop = 1'b0;
        settle();
        chk("edrain1_flush", flush_done, 0);
        advance();
        settle();
        chk("edrain2_flush", flush_done, 1);
        advance();
        settle();
        chk("edrain3_flush", flush_done, 0);

        // reset in the middle of a drain
        do_reset();
        qa.push_back({11'd1, 11'd5});
        qb.push_back({11'd2, 11'd6});
        eop = 1'b1;
        settle();
        advance();
        eop = 1'b0;
        out_ready = 1'b0;
        settle();
        chk("rdrain_stall", {a_rd_en, b_rd_en}, 2'b00);
        advance();
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
        out_ready = 1'b1;
        settle();
        chk("rdrain_valid", out_valid, 0);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) settle();
            chk($sformatf("rdrain%0d_flush", c), flush_done, 0);
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
